uart_rx_fifo: RTL and testbench

- Parametrised UART receiver with a first-word-fall-through capture FIFO.
- Generalises the bench-side UART byte monitor into a synthesizable block with configurable frame format, error detection and buffering.
- Used as the UART receive path in the TinyQV peripheral set and reused in benches as a checked monitor.
- Sits between a pad input (rxd) and a CPU/bench pop interface.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_sync_fifo.sv | 75 +++++++
 rtl/uart_rx_fifo.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive path.
//   state_e   - receiver frame states
//   PAR_*     - values accepted by the PARITY parameter of uart_rx_fifo
//   ctr_width - width of the bit-timing counter for a given CLKS_PER_BIT
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // The counter only ever holds values up to CLKS_PER_BIT-1 (CLKS_PER_BIT >= 8).
  function automatic int ctr_width(input int clks_per_bit);
    return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// uart_rx_sync_fifo: single-clock first-word-fall-through FIFO.
//   clk_i, rst_n_i - clock and synchronous active-low reset (control only)
//   push_i         - write push_data_i; accepted when not full, or when full
//                    and a pop happens in the same cycle
//   pop_i          - advance the head; ignored while empty
//   rd_data_o      - head entry, forced to 0 while empty
//   count_o        - exact occupancy 0..DEPTH
//   full_o/empty_o - occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_rx_sync_fifo
  import uart_rx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok, push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver feeding a first-word-fall-through capture FIFO.
//   clk, rst_n  - clock and synchronous active-low reset
//   rxd         - asynchronous serial input, idle high
//   rd_en       - pop the head entry while rd_valid is high
//   rd_data     - head entry (0 while empty)
//   rd_valid    - FIFO non-empty
//   count       - FIFO occupancy
//   busy        - receiver is not IDLE
//   frame_err   - sticky, a stop bit was sampled low
//   parity_err  - sticky, parity mismatch on an otherwise good frame
//   overflow    - sticky, a good frame was dropped because the FIFO was full
//   err_clr     - clears the sticky flags (a same-cycle set wins)
// Build option: define UART_RX_MAJORITY_EN to take every bit sample as the
// 2-of-3 majority at mid-1/mid/mid+1 (one extra clock of latency).
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rxd,
  input  logic                        rd_en,
  output logic [DATA_BITS-1:0]        rd_data,
  output logic                        rd_valid,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        busy,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overflow,
  input  logic                        err_clr
);

  localparam int CW = ctr_width(CLKS_PER_BIT);
  localparam int IW = 4;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // With majority voting the decision moves one clock later (mid+1); the
  // offset is applied once at START and every later bit keeps the same phase.
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1 + MAJ);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  logic [1:0]           sync_q;
  logic                 rs;
  logic                 sample;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_pend_q, par_pend_d;
  logic                 frame_err_q, parity_err_q, overflow_q;

  logic                 tick;
  logic                 push;
  logic                 set_ferr, set_perr, set_ovf;
  logic                 par_x;
  logic                 fifo_full, fifo_empty;

  // Stage: 2-flop synchroniser, idles high.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rxd};
  end
  assign rs = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // hist_q[0] is rs one clock ago (mid), hist_q[1] two clocks ago (mid-1).
  logic [1:0] hist_q;
  always_ff @(posedge clk) begin
    if (!rst_n) hist_q <= 2'b11;
    else        hist_q <= {hist_q[0], rs};
  end
  assign sample = maj3(rs, hist_q[0], hist_q[1]);
`else
  assign sample = rs;
`endif

  // Stage: frame FSM.
  assign tick  = (cnt_q == '0);
  assign par_x = (^shift_q) ^ sample;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_pend_d = par_pend_q;
    push       = 1'b0;
    set_ferr   = 1'b0;
    set_perr   = 1'b0;

    case (state_q)
      IDLE: begin
        // IDLE is only entered with rs high, so a low level is a falling edge.
        if (!rs) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end

      START: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else if (sample) begin
          state_d = IDLE;
        end else begin
          state_d    = DATA;
          cnt_d      = FULL_LOAD;
          idx_d      = '0;
          par_pend_d = 1'b0;
        end
      end

      DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {sample, shift_q[DATA_BITS-1:1]};
          cnt_d   = FULL_LOAD;
          if (idx_q == IW'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? uart_rx_pkg::PARITY : STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      uart_rx_pkg::PARITY: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // par_x is 1 when data plus parity bit hold an odd number of ones.
          par_pend_d = (PARITY == PAR_ODD) ? ~par_x : par_x;
          cnt_d      = FULL_LOAD;
          idx_d      = '0;
          state_d    = STOP;
        end
      end

      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!sample) begin
          set_ferr = 1'b1;
          state_d  = WAIT_IDLE;
        end else if (idx_q == IW'(STOP_BITS - 1)) begin
          if (par_pend_q) set_perr = 1'b1;
          else            push     = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
          cnt_d = FULL_LOAD;
        end
      end

      WAIT_IDLE: begin
        // Holds through a break so it reports a single frame error.
        if (rs) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      par_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      par_pend_q <= par_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // Stage: sticky error flags, set has priority over clear.
  assign set_ovf = push & fifo_full & ~(rd_en & rd_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_err_q  <= set_ferr | (frame_err_q  & ~err_clr);
      parity_err_q <= set_perr | (parity_err_q & ~err_clr);
      overflow_q   <= set_ovf  | (overflow_q   & ~err_clr);
    end
  end

  // Stage: capture FIFO.
  uart_rx_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (rd_en),
    .rd_data_o   (rd_data),
    .count_o     (count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign rd_valid   = ~fifo_empty;
  assign busy       = (state_q != IDLE);
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo. Main instance is 8N1 at
// 217 clocks/bit with a 16-entry FIFO; a second instance runs even parity at
// 16 clocks/bit.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] count;
  logic       busy, frame_err, parity_err, overflow;

  logic       rxd2 = 1'b1;
  logic       rd_en2 = 1'b0;
  logic       err_clr2 = 1'b0;
  logic [7:0] rd_data2;
  logic       rd_valid2;
  logic [4:0] count2;
  logic       busy2, frame_err2, parity_err2, overflow2;

  int errs = 0;
  int checks = 0;
  int lat = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT (217), .DATA_BITS (8), .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (16)
  ) dut (
    .clk (clk), .rst_n (rst_n), .rxd (rxd), .rd_en (rd_en),
    .rd_data (rd_data), .rd_valid (rd_valid), .count (count), .busy (busy),
    .frame_err (frame_err), .parity_err (parity_err), .overflow (overflow),
    .err_clr (err_clr)
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT (16), .DATA_BITS (8), .PARITY (2), .STOP_BITS (1), .FIFO_DEPTH (16)
  ) dut_par (
    .clk (clk), .rst_n (rst_n), .rxd (rxd2), .rd_en (rd_en2),
    .rd_data (rd_data2), .rd_valid (rd_valid2), .count (count2), .busy (busy2),
    .frame_err (frame_err2), .parity_err (parity_err2), .overflow (overflow2),
    .err_clr (err_clr2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks; stimulus always changes 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rxd2 = v;
    else     rxd  = v;
  endtask

  task automatic send_frame(input bit sel, input int cpb, input logic [7:0] d,
                            input bit use_par, input logic pbit, input logic sbit);
    drive(sel, 1'b0);
    step(cpb);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      step(cpb);
    end
    if (use_par) begin
      drive(sel, pbit);
      step(cpb);
    end
    drive(sel, sbit);
    step(cpb);
    drive(sel, 1'b1);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  logic [7:0] post_str [5];

  initial begin
    post_str[0] = 8'h50; post_str[1] = 8'h4F; post_str[2] = 8'h53;
    post_str[3] = 8'h54; post_str[4] = 8'h0A;

    // Reset state
    step(4);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {frame_err, parity_err, overflow}, 0);
    rst_n = 1'b1;
    step(5);

    // Single 'P' frame with push latency measured from the falling edge
    fork
      send_frame(0, 217, 8'h50, 0, 1'b0, 1'b1);
      begin
        lat = 0;
        while (!rd_valid && lat < 3000) begin
          step(1);
          lat++;
        end
      end
    join
    chk("p_latency", lat, 2 + 108 + 9 * 217 + 1);
    chk("p_rd_valid", rd_valid, 1);
    chk("p_rd_data", rd_data, 8'h50);
    chk("p_count", count, 1);
    chk("p_flags", {frame_err, parity_err, overflow}, 0);
    pop();
    chk("p_pop_empty", rd_valid, 0);
    pop();
    chk("pop_when_empty_count", count, 0);

    // "POST\n" back to back
    for (int i = 0; i < 5; i++) send_frame(0, 217, post_str[i], 0, 1'b0, 1'b1);
    step(2);
    chk("post_count", count, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("post_data%0d", i), rd_data, post_str[i]);
      pop();
    end
    chk("post_drained", rd_valid, 0);

    // Fill, overflow, then push with simultaneous pop while full
    for (int i = 0; i < 16; i++) send_frame(0, 217, 8'(8'h10 + i), 0, 1'b0, 1'b1);
    chk("fill_count", count, 16);
    chk("fill_overflow", overflow, 0);
    send_frame(0, 217, 8'hEE, 0, 1'b0, 1'b1);
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", rd_data, 8'h10);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    fork
      send_frame(0, 217, 8'hDD, 0, 1'b0, 1'b1);
      begin
        step(2063);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
      end
    join
    chk("fullpop_count", count, 16);
    chk("fullpop_overflow", overflow, 0);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("drain%0d", i), rd_data, 8'(8'h11 + i));
      pop();
    end
    chk("drain_last", rd_data, 8'hDD);
    pop();
    chk("drain_empty", rd_valid, 0);

    // Even-parity instance: bad parity bit, then good parity bit
    send_frame(1, 16, 8'h03, 1, 1'b1, 1'b1);
    step(3);
    chk("par_bad_flag", parity_err2, 1);
    chk("par_bad_count", count2, 0);
    chk("par_bad_ferr", frame_err2, 0);
    send_frame(1, 16, 8'h03, 1, 1'b0, 1'b1);
    step(3);
    chk("par_good_valid", rd_valid2, 1);
    chk("par_good_data", rd_data2, 8'h03);
    chk("par_good_misc", {busy2, overflow2}, 0);

    // Stop bit low on 0xA5
    send_frame(0, 217, 8'hA5, 0, 1'b0, 1'b0);
    step(4);
    chk("ferr_flag", frame_err, 1);
    chk("ferr_count", count, 0);
    chk("ferr_busy", busy, 0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("ferr_clr", frame_err, 0);

    // Break: line low 5000 clocks yields one frame error only
    rxd = 1'b0;
    step(2500);
    chk("brk_ferr", frame_err, 1);
    chk("brk_busy", busy, 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    step(2499);
    chk("brk_single", frame_err, 0);
    chk("brk_wait_busy", busy, 1);
    rxd = 1'b1;
    step(10);
    chk("brk_idle", busy, 0);
    chk("brk_count", count, 0);
    send_frame(0, 217, 8'h3C, 0, 1'b0, 1'b1);
    step(2);
    chk("brk_next_data", rd_data, 8'h3C);
    chk("brk_next_count", count, 1);
    chk("brk_next_ferr", frame_err, 0);
    pop();

    // 50-clock glitch: false start
    rxd = 1'b0;
    step(10);
    chk("glitch_busy", busy, 1);
    step(40);
    rxd = 1'b1;
    step(200);
    chk("glitch_idle", busy, 0);
    chk("glitch_count", count, 0);
    chk("glitch_flags", {frame_err, parity_err, overflow}, 0);

    // Reset in the middle of a frame
    send_frame(0, 217, 8'h77, 0, 1'b0, 1'b1);
    send_frame(0, 217, 8'h11, 0, 1'b0, 1'b0);
    step(4);
    chk("pre_rst_state", {frame_err, count}, {1'b1, 5'd1});
    rxd = 1'b0;
    step(217);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0];
      step(217);
    end
    rxd = 1'b1;
    step(100);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    step(1);
    chk("midrst_outputs", {rd_valid, rd_data, count, busy, frame_err, parity_err, overflow}, 0);
    rst_n = 1'b1;
    step(20);
    send_frame(0, 217, 8'h96, 0, 1'b0, 1'b1);
    step(2);
    chk("post_rst_data", rd_data, 8'h96);
    chk("post_rst_count", count, 1);
    chk("post_rst_flags", {frame_err, parity_err, overflow}, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
